// File: rtl/alu_issue_if.sv
// Issue bundle between the decode/regfile stage, the ALU issue register and the ALU.
// The issue unit itself sits on the slave side; the surrounding pipeline uses master.
interface alu_issue_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        flush;

   logic        out_valid;
   logic        out_ready;
   logic [31:0] A;
   logic [31:0] B;
   logic        isAdd, isSub, isMul, isDiv, isMod, isCmp, isAnd;
   logic        isOr, isNot, isMov, isLsl, isLsr, isAsr;
   logic [3:0]  rd;
   logic        wb_en;
   logic        illegal;
   logic        alu_eq;
   logic        alu_gt;
   logic        flag_eq;
   logic        flag_gt;

   modport slave (
      input  in_valid, instr, rs1_data, rs2_data, flush, out_ready, alu_eq, alu_gt,
      output in_ready, out_valid, A, B, rd, wb_en, illegal, flag_eq, flag_gt,
      output isAdd, isSub, isMul, isDiv, isMod, isCmp, isAnd,
      output isOr, isNot, isMov, isLsl, isLsr, isAsr
   );

   modport master (
      output in_valid, instr, rs1_data, rs2_data, flush, out_ready, alu_eq, alu_gt,
      input  in_ready, out_valid, A, B, rd, wb_en, illegal, flag_eq, flag_gt,
      input  isAdd, isSub, isMul, isDiv, isMod, isCmp, isAnd,
      input  isOr, isNot, isMov, isLsl, isLsr, isAsr
   );
endinterface

// File: rtl/alu_issue_unit.sv
// SimpleRISC ALU issue stage: decodes one instruction into a registered operand/control
// bundle behind a valid/ready handshake, and owns the architectural eq/gt flags.
module alu_issue_unit (
   input  logic       clk,
   input  logic       rst,
   alu_issue_if.slave bus
);

   localparam int unsigned NumCtrl = 13;
   localparam int unsigned CtrlAdd = 0;
   localparam int unsigned CtrlCmp = 5;

   localparam logic [4:0] OpLastAlu = 5'b01100;
   localparam logic [4:0] OpCmp     = 5'b00101;
   localparam logic [4:0] OpLd      = 5'b01110;
   localparam logic [4:0] OpSt      = 5'b01111;
   localparam logic [4:0] OpLastDef = 5'b10100;

   logic [4:0]  opcode;
   logic        imm_sel;
   logic [1:0]  imm_mod;
   logic [15:0] imm;
   logic [31:0] imm_ext;

   logic [NumCtrl-1:0] ctrl_dec;
   logic               wb_dec;
   logic               illegal_dec;
   logic               accept;
   logic               in_ready;

   logic               out_valid_d, out_valid_q;
   logic [31:0]        a_d, a_q;
   logic [31:0]        b_d, b_q;
   logic [NumCtrl-1:0] ctrl_d, ctrl_q;
   logic [3:0]         rd_d, rd_q;
   logic               wb_en_d, wb_en_q;
   logic               illegal_d, illegal_q;
   logic               flag_eq_d, flag_eq_q;
   logic               flag_gt_d, flag_gt_q;

   assign opcode  = bus.instr[31:27];
   assign imm_sel = bus.instr[26];
   assign imm_mod = bus.instr[17:16];
   assign imm     = bus.instr[15:0];

   always_comb begin
      case (imm_mod)
         2'b01:   imm_ext = {16'h0000, imm};
         2'b10:   imm_ext = {imm, 16'h0000};
         default: imm_ext = {{16{imm[15]}}, imm};
      endcase
   end

   // Opcodes 0..12 map straight onto the control index; ld/st reuse the adder for addressing.
   always_comb begin
      ctrl_dec    = '0;
      wb_dec      = 1'b0;
      illegal_dec = 1'b0;
      if (opcode <= OpLastAlu) begin
         ctrl_dec = NumCtrl'(1) << opcode;
         wb_dec   = (opcode != OpCmp);
      end else if (opcode == OpLd || opcode == OpSt) begin
         ctrl_dec[CtrlAdd] = 1'b1;
         wb_dec            = (opcode == OpLd);
      end else if (opcode > OpLastDef) begin
         illegal_dec = 1'b1;
      end
   end

   assign in_ready = (!out_valid_q || bus.out_ready) && !bus.flush;
   assign accept   = bus.in_valid && in_ready;

   always_comb begin
      out_valid_d = out_valid_q;
      a_d         = a_q;
      b_d         = b_q;
      ctrl_d      = ctrl_q;
      rd_d        = rd_q;
      wb_en_d     = wb_en_q;
      illegal_d   = illegal_q;
      flag_eq_d   = flag_eq_q;
      flag_gt_d   = flag_gt_q;

      if (bus.flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d = 1'b1;
         a_d         = bus.rs1_data;
         b_d         = imm_sel ? imm_ext : bus.rs2_data;
         ctrl_d      = ctrl_dec;
         rd_d        = bus.instr[25:22];
         wb_en_d     = wb_dec;
         illegal_d   = illegal_dec;
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end

      // A cmp that transfers this cycle has completed, so a concurrent flush does not stop it.
      if (out_valid_q && bus.out_ready && ctrl_q[CtrlCmp]) begin
         flag_eq_d = bus.alu_eq;
         flag_gt_d = bus.alu_gt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         ctrl_q      <= '0;
         rd_q        <= '0;
         wb_en_q     <= 1'b0;
         illegal_q   <= 1'b0;
         flag_eq_q   <= 1'b0;
         flag_gt_q   <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         a_q         <= a_d;
         b_q         <= b_d;
         ctrl_q      <= ctrl_d;
         rd_q        <= rd_d;
         wb_en_q     <= wb_en_d;
         illegal_q   <= illegal_d;
         flag_eq_q   <= flag_eq_d;
         flag_gt_q   <= flag_gt_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.A         = a_q;
   assign bus.B         = b_q;
   assign bus.rd        = rd_q;
   assign bus.wb_en     = wb_en_q;
   assign bus.illegal   = illegal_q;
   assign bus.flag_eq   = flag_eq_q;
   assign bus.flag_gt   = flag_gt_q;

   assign bus.isAdd = ctrl_q[0];
   assign bus.isSub = ctrl_q[1];
   assign bus.isMul = ctrl_q[2];
   assign bus.isDiv = ctrl_q[3];
   assign bus.isMod = ctrl_q[4];
   assign bus.isCmp = ctrl_q[5];
   assign bus.isAnd = ctrl_q[6];
   assign bus.isOr  = ctrl_q[7];
   assign bus.isNot = ctrl_q[8];
   assign bus.isMov = ctrl_q[9];
   assign bus.isLsl = ctrl_q[10];
   assign bus.isLsr = ctrl_q[11];
   assign bus.isAsr = ctrl_q[12];

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit: decode, immediates, handshake stalls, flush,
// flag updates and asynchronous reset, against hand-computed expectations.
module tb_alu_issue_unit;

   logic clk;
   logic rst;

   alu_issue_if bus ();

   alu_issue_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   logic [12:0] ctrl;
   assign ctrl = {bus.isAsr, bus.isLsr, bus.isLsl, bus.isMov, bus.isNot, bus.isOr, bus.isAnd,
                  bus.isCmp, bus.isMod, bus.isDiv, bus.isMul, bus.isSub, bus.isAdd};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mk_r(input logic [4:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] rs2);
      return {op, 1'b0, rd, rs1, rs2, 14'h0};
   endfunction

   function automatic logic [31:0] mk_i(input logic [4:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [1:0] md,
                                        input logic [15:0] imm);
      return {op, 1'b1, rd, rs1, md, imm};
   endfunction

   logic [4:0]  tbl_op   [5] = '{5'b01101, 5'b01110, 5'b01111, 5'b10000, 5'b10100};
   logic [12:0] tbl_ctrl [5] = '{13'h0, 13'h1, 13'h1, 13'h0, 13'h0};
   logic        tbl_wb   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
   logic [1:0]  mov_mod  [3] = '{2'b00, 2'b01, 2'b10};
   logic [31:0] mov_b    [3] = '{32'hFFFF_FFFF, 32'h0000_FFFF, 32'hFFFF_0000};

   initial begin
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.instr    = '0;
      bus.rs1_data = '0;
      bus.rs2_data = '0;
      bus.flush    = 1'b0;
      bus.out_ready = 1'b0;
      bus.alu_eq   = 1'b0;
      bus.alu_gt   = 1'b0;

      #12;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_A", bus.A, 32'd0);
      check("rst_B", bus.B, 32'd0);
      check("rst_ctrl", 32'(ctrl), 32'd0);
      check("rst_rd_wb_ill", {27'd0, bus.rd, bus.wb_en, bus.illegal} , 32'd0);
      check("rst_flags", {30'd0, bus.flag_eq, bus.flag_gt}, 32'd0);
      rst = 1'b0;
      #1;
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);

      // add r1,r2,r3
      bus.instr     = mk_r(5'b00000, 4'd1, 4'd2, 4'd3);
      bus.rs1_data  = 32'd5;
      bus.rs2_data  = 32'd7;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      step();
      bus.in_valid = 1'b0;
      check("add_valid", 32'(bus.out_valid), 32'd1);
      check("add_ctrl", 32'(ctrl), 32'h1);
      check("add_A", bus.A, 32'd5);
      check("add_B", bus.B, 32'd7);
      check("add_rd", 32'(bus.rd), 32'd1);
      check("add_wb", 32'(bus.wb_en), 32'd1);
      step();
      check("add_drain", 32'(bus.out_valid), 32'd0);

      // mov r4, #0xFFFF under each immediate mode
      for (int i = 0; i < 3; i++) begin
         bus.instr    = mk_i(5'b01001, 4'd4, 4'd0, mov_mod[i], 16'hFFFF);
         bus.rs2_data = 32'h1234_5678;
         bus.in_valid = 1'b1;
         step();
         check($sformatf("mov_B_mod%0d", i), bus.B, mov_b[i]);
         check($sformatf("mov_ctrl_%0d", i), 32'(ctrl), 32'h200);
      end
      bus.in_valid = 1'b0;
      step();

      // ld/st/nop/branches decode
      for (int i = 0; i < 5; i++) begin
         bus.instr    = mk_i(tbl_op[i], 4'd2, 4'd3, 2'b00, 16'h0010);
         bus.in_valid = 1'b1;
         step();
         check($sformatf("misc_ctrl_op%0d", tbl_op[i]), 32'(ctrl), 32'(tbl_ctrl[i]));
         check($sformatf("misc_wb_op%0d", tbl_op[i]), 32'(bus.wb_en), 32'(tbl_wb[i]));
         check($sformatf("misc_ill_op%0d", tbl_op[i]), 32'(bus.illegal), 32'd0);
      end
      bus.in_valid = 1'b0;
      step();

      // cmp stalled for 3 cycles, then consumed
      bus.instr     = mk_r(5'b00101, 4'd0, 4'd6, 4'd7);
      bus.rs1_data  = 32'd9;
      bus.rs2_data  = 32'd9;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      step();
      bus.in_valid = 1'b0;
      bus.rs1_data = 32'd1;
      bus.alu_eq   = 1'b1;
      bus.alu_gt   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("cmp_stall_valid%0d", i), 32'(bus.out_valid), 32'd1);
         check($sformatf("cmp_stall_A%0d", i), bus.A, 32'd9);
         check($sformatf("cmp_stall_ctrl%0d", i), 32'(ctrl), 32'h20);
         check($sformatf("cmp_stall_flags%0d", i), {30'd0, bus.flag_eq, bus.flag_gt}, 32'd0);
         check($sformatf("cmp_stall_rdy%0d", i), 32'(bus.in_ready), 32'd0);
      end
      check("cmp_wb", 32'(bus.wb_en), 32'd0);
      bus.out_ready = 1'b1;
      #1;
      check("cmp_rdy_release", 32'(bus.in_ready), 32'd1);
      step();
      check("cmp_flags", {30'd0, bus.flag_eq, bus.flag_gt}, 32'd2);
      check("cmp_drain", 32'(bus.out_valid), 32'd0);

      // sub then lsl back to back
      bus.instr    = mk_r(5'b00001, 4'd3, 4'd1, 4'd2);
      bus.in_valid = 1'b1;
      bus.alu_eq   = 1'b0;
      bus.alu_gt   = 1'b1;
      step();
      bus.instr = mk_i(5'b01010, 4'd5, 4'd1, 2'b01, 16'h0004);
      #1;
      check("b2b_rdy", 32'(bus.in_ready), 32'd1);
      check("b2b_sub", 32'(ctrl), 32'h2);
      step();
      bus.in_valid = 1'b0;
      check("b2b_lsl_valid", 32'(bus.out_valid), 32'd1);
      check("b2b_lsl", 32'(ctrl), 32'h400);
      check("b2b_lsl_B", bus.B, 32'd4);
      check("b2b_flags_held", {30'd0, bus.flag_eq, bus.flag_gt}, 32'd2);
      step();

      // illegal opcode held, then flushed together with an incoming add
      bus.out_ready = 1'b0;
      bus.instr     = mk_r(5'b11000, 4'd7, 4'd1, 4'd2);
      bus.in_valid  = 1'b1;
      step();
      check("ill_flag", 32'(bus.illegal), 32'd1);
      check("ill_ctrl", 32'(ctrl), 32'd0);
      check("ill_wb", 32'(bus.wb_en), 32'd0);
      bus.instr = mk_r(5'b00000, 4'd1, 4'd2, 4'd3);
      bus.flush = 1'b1;
      #1;
      check("flush_rdy", 32'(bus.in_ready), 32'd0);
      step();
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      check("flush_valid", 32'(bus.out_valid), 32'd0);
      check("flush_flags", {30'd0, bus.flag_eq, bus.flag_gt}, 32'd2);
      check("flush_dropped", 32'(bus.illegal), 32'd1);

      // cmp transfer concurrent with flush still updates flags
      bus.instr    = mk_r(5'b00101, 4'd0, 4'd1, 4'd2);
      bus.in_valid = 1'b1;
      step();
      bus.in_valid  = 1'b0;
      bus.alu_eq    = 1'b0;
      bus.alu_gt    = 1'b1;
      bus.out_ready = 1'b1;
      bus.flush     = 1'b1;
      step();
      bus.flush = 1'b0;
      check("cmpflush_flags", {30'd0, bus.flag_eq, bus.flag_gt}, 32'd1);
      check("cmpflush_valid", 32'(bus.out_valid), 32'd0);

      // asynchronous reset while stalled
      bus.out_ready = 1'b0;
      bus.instr     = mk_r(5'b00000, 4'd1, 4'd2, 4'd3);
      bus.in_valid  = 1'b1;
      step();
      bus.in_valid = 1'b0;
      check("arst_pre_valid", 32'(bus.out_valid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid", 32'(bus.out_valid), 32'd0);
      check("arst_flags", {30'd0, bus.flag_eq, bus.flag_gt}, 32'd0);
      check("arst_ctrl", 32'(ctrl), 32'd0);
      rst = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_issue_unit.md
ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
Parameters: none.
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk, rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 in_valid  input  1  instr and operand data are valid.
REQ-005 in_ready  output  1  block accepts the instruction this cycle.
REQ-006 instr  input  32  SimpleRISC word: opcode[31:27], I[26], rd[25:22], rs1[21:18], rs2[17:14], mod[17:16], imm[15:0].
REQ-007 rs1_data, rs2_data  input  32 each  register-file read data for rs1/rs2.
REQ-008 flush  input  1  discard the held and incoming instruction.
REQ-009 out_valid  output  1  the registered issue bundle is valid.
REQ-010 out_ready  input  1  downstream consumes the bundle.
REQ-011 A, B  output  32 each  ALU operands.
REQ-012 isAdd..isAsr  output  1 each  13 one-hot ALU controls: isAdd, isSub, isMul, isDiv, isMod, isCmp, isAnd, isOr, isNot, isMov, isLsl, isLsr, isAsr.
REQ-013 rd  output  4  destination register; wb_en  output  1  result is written back.
REQ-014 illegal  output  1  held instruction has an undefined opcode.
REQ-015 alu_eq, alu_gt  input  1 each  combinational flag outputs of the ALU for the current A/B.
REQ-016 flag_eq, flag_gt  output  1 each  architectural flags register.

Function
REQ-017 in_ready SHALL equal (!out_valid || out_ready) && !flush.
REQ-018 On in_valid && in_ready the block SHALL register the decoded bundle and set out_valid=1 at the next edge (latency 1 cycle).
REQ-019 When out_valid && out_ready and no new accept, out_valid SHALL clear at the next edge; simultaneous consume and accept SHALL reload with no bubble.
REQ-020 While out_valid && !out_ready, all bundle outputs SHALL remain stable.
REQ-021 flush SHALL clear out_valid at the next edge and drop any input presented that cycle; flush has priority over accept.
REQ-022 Opcodes 00000-01100 SHALL assert exactly one control in REQ-012 order (add, sub, mul, div, mod, cmp, and, or, not, mov, lsl, lsr, asr).
REQ-023 ld (01110) and st (01111) SHALL assert isAdd only (address = rs1 + imm).
REQ-024 nop (01101), beq, bgt, b, call, ret (10000-10100) SHALL assert no control; wb_en=0.
REQ-025 Opcodes 10101-11111 SHALL assert no control, wb_en=0, illegal=1; all others illegal=0.
REQ-026 wb_en SHALL be 1 for opcodes 00000-01100 except cmp, and for ld; 0 otherwise.
REQ-027 A SHALL be rs1_data; B SHALL be rs2_data when I=0, else the extended immediate.
REQ-028 Immediate: mod 00 or 11 sign-extend imm[15:0]; 01 zero-extend; 10 imm[15:0]<<16.
REQ-029 Flags SHALL load {alu_eq, alu_gt} at the edge where out_valid && out_ready && isCmp; otherwise hold.
REQ-030 A flush in the same cycle as a cmp transfer SHALL NOT block that flag update (the transfer has completed).

Reset
REQ-031 On rst: out_valid=0, A=B=0, all controls 0, rd=0, wb_en=0, illegal=0, flag_eq=0, flag_gt=0; in_ready=1 after release.
REQ-032 rst asserted mid-stall SHALL discard the held bundle immediately (asynchronous).

Verification
REQ-033 add r1,r2,r3 with rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, isAdd=1, A=5, B=7, rd=1, wb_en=1.
REQ-034 mov r4, imm 0xFFFF mod 00 -> B=0xFFFFFFFF; mod 01 -> 0x0000FFFF; mod 10 -> 0xFFFF0000; isMov=1.
REQ-035 cmp with alu_eq=1, alu_gt=0, out_ready held 0 for 3 cycles -> bundle stable, flags unchanged; out_ready=1 -> flag_eq=1 next edge, wb_en=0.
REQ-036 Back-to-back sub then lsl with out_ready=1 -> in_ready stays 1, two consecutive valid beats, no bubble.
REQ-037 opcode 11000 -> illegal=1, all controls 0, wb_en=0; flush while held -> out_valid=0 next cycle, flags unchanged.
REQ-038 rst pulse while out_valid=1 stalled -> out_valid=0 and flags 0 without waiting for a clock edge.
